// File: rtl/tfhe_pbs_launcher.sv
// PBS launch controller: turns the start_pbs control level into one valid/ready launch of the
// PBS core, then tracks the run to completion with sticky status, cycle and run counters.
module tfhe_pbs_launcher #(
    parameter int unsigned CYC_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned RUN_W          = 16
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             start_pbs,
    input  logic [1:0]       hbm_select,
    output logic             core_start_valid,
    input  logic             core_start_ready,
    output logic [1:0]       core_hbm_select,
    input  logic             core_done,
    input  logic             core_error,
    output logic             pbs_busy,
    output logic             pbs_done,
    output logic             pbs_error,
    output logic             pbs_timeout,
    output logic [CYC_W-1:0] pbs_cycles,
    output logic [RUN_W-1:0] pbs_count
);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    localparam logic [CYC_W-1:0] TIMEOUT_LIM = CYC_W'(TIMEOUT_CYCLES);

    state_t           state, state_nxt;
    logic             start_q;
    logic             rise;
    logic             watchdog;

    logic             valid_nxt;
    logic [1:0]       hbm_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             error_nxt;
    logic             timeout_nxt;
    logic [CYC_W-1:0] cycles_nxt;
    logic [RUN_W-1:0] count_nxt;

    assign rise     = start_pbs & ~start_q;
    // The watchdog looks at the registered count, so it trips one clock after the limit is reached.
    assign watchdog = (TIMEOUT_CYCLES != 0) && (pbs_cycles >= TIMEOUT_LIM);

    // NOTE: every *_nxt gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_nxt   = state;
        valid_nxt   = core_start_valid;
        hbm_nxt     = core_hbm_select;
        busy_nxt    = pbs_busy;
        done_nxt    = pbs_done;
        error_nxt   = pbs_error;
        timeout_nxt = pbs_timeout;
        cycles_nxt  = pbs_cycles;
        count_nxt   = pbs_count;

        if ((state == LAUNCH || state == RUN) && !(&pbs_cycles))
            cycles_nxt = pbs_cycles + CYC_W'(1);

        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt   = LAUNCH;
                    hbm_nxt     = hbm_select;
                    valid_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    cycles_nxt  = '0;
                    done_nxt    = 1'b0;
                    error_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end
            end
            LAUNCH: begin
                if (core_start_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = RUN;
                end else if (watchdog) begin
                    valid_nxt   = 1'b0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            RUN: begin
                // A completion pulse takes priority over a watchdog trip on the same clock.
                if (core_done || core_error) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    error_nxt = core_error;
                    count_nxt = pbs_count + RUN_W'(1);
                    state_nxt = DONE;
                end else if (watchdog) begin
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (!start_pbs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state            <= IDLE;
            // start_q comes out of reset high so a start_pbs level held through reset is not a rise.
            start_q          <= 1'b1;
            core_start_valid <= 1'b0;
            core_hbm_select  <= 2'b00;
            pbs_busy         <= 1'b0;
            pbs_done         <= 1'b0;
            pbs_error        <= 1'b0;
            pbs_timeout      <= 1'b0;
            pbs_cycles       <= '0;
            pbs_count        <= '0;
        end else begin
            state            <= state_nxt;
            start_q          <= start_pbs;
            core_start_valid <= valid_nxt;
            core_hbm_select  <= hbm_nxt;
            pbs_busy         <= busy_nxt;
            pbs_done         <= done_nxt;
            pbs_error        <= error_nxt;
            pbs_timeout      <= timeout_nxt;
            pbs_cycles       <= cycles_nxt;
            pbs_count        <= count_nxt;
        end
    end

endmodule
